cfg_burst_passer: RTL

- Parametrised successor to the byte-wide configuration passer.
- Pops a header word from a show-ahead command FIFO, then moves a burst of words into or out of the coefficient/config register file.
- Adds three things the previous block lacked: generic data/address/count widths, an address auto-increment mode, and a read-back mode that streams register contents to a TX FIFO with back-pressure.
- Sits between the host-side RX FIFO and the FIR register bank.

---
 rtl/cfg_pkg.sv | 34 +++
 rtl/cfg_burst_passer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/cfg_pkg.sv
// Shared definitions for the burst configuration passer: FSM states, header
// field positions and the parameter legality rule.
package cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } cfg_state_e;

    // Header layout: [DATA_W-1]=W, [DATA_W-2]=INC, ADDR above CNT, CNT at bit 0.
    function automatic int unsigned hdr_w_bit(input int unsigned data_w);
        return data_w - 1;
    endfunction

    function automatic int unsigned hdr_inc_bit(input int unsigned data_w);
        return data_w - 2;
    endfunction

    function automatic int unsigned hdr_addr_lsb(input int unsigned cnt_w);
        return cnt_w;
    endfunction

    function automatic int unsigned hdr_cnt_lsb();
        return 0;
    endfunction

    function automatic bit hdr_fits(input int unsigned data_w,
                                    input int unsigned addr_w,
                                    input int unsigned cnt_w);
        return data_w >= (2 + addr_w + cnt_w);
    endfunction

endpackage

// File: rtl/cfg_burst_passer.sv
// Header-driven burst mover between a show-ahead RX FIFO, a register file and
// a TX FIFO: write bursts land in the register file, read bursts stream out.
module cfg_burst_passer
    import cfg_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned CNT_W  = 3
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              Empty,
    input  logic [DATA_W-1:0] Data,
    output logic              RINC,
    output logic              WrEn,
    output logic [DATA_W-1:0] WrData,
    output logic [ADDR_W-1:0] RegAddr,
    output logic              RdEn,
    input  logic [DATA_W-1:0] RdData,
    input  logic              TxFull,
    output logic              TxWr,
    output logic [DATA_W-1:0] TxData,
    output logic              Busy
);

    localparam int unsigned W_BIT    = hdr_w_bit(DATA_W);
    localparam int unsigned INC_BIT  = hdr_inc_bit(DATA_W);
    localparam int unsigned ADDR_LSB = hdr_addr_lsb(CNT_W);
    localparam int unsigned CNT_LSB  = hdr_cnt_lsb();

    if (!hdr_fits(DATA_W, ADDR_W, CNT_W)) begin : g_bad_params
        $error("cfg_burst_passer: DATA_W must be >= 2+ADDR_W+CNT_W");
    end

    cfg_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              inc_q,   inc_d;

    logic              hdr_w;
    logic              hdr_inc;
    logic [ADDR_W-1:0] hdr_addr;
    logic [CNT_W-1:0]  hdr_cnt;

    logic rinc_c, wren_c, rden_c, txwr_c;

    always_comb begin
        hdr_w    = Data[W_BIT];
        hdr_inc  = Data[INC_BIT];
        hdr_addr = Data[ADDR_LSB +: ADDR_W];
        hdr_cnt  = Data[CNT_LSB +: CNT_W];
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            inc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            inc_q   <= inc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        inc_d   = inc_q;
        rinc_c  = 1'b0;
        wren_c  = 1'b0;
        rden_c  = 1'b0;
        txwr_c  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!Empty) begin
                    rinc_c = 1'b1;
                    addr_d = hdr_addr;
                    cnt_d  = hdr_cnt;
                    inc_d  = hdr_inc;
                    // A zero-length header is consumed without leaving IDLE.
                    if (hdr_cnt != '0) begin
                        state_d = hdr_w ? WRITE : READ;
                    end
                end
            end

            WRITE: begin
                if (!Empty) begin
                    rinc_c = 1'b1;
                    wren_c = 1'b1;
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (inc_q) begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end

            READ: begin
                if (!TxFull) begin
                    rden_c = 1'b1;
                    txwr_c = 1'b1;
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (inc_q) begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes are masked by RSTn so nothing fires while reset is held.
    always_comb begin
        RINC    = rinc_c & RSTn;
        WrEn    = wren_c & RSTn;
        RdEn    = rden_c & RSTn;
        TxWr    = txwr_c & RSTn;
        Busy    = (state_q != IDLE) & RSTn;
        RegAddr = addr_q;
        WrData  = Data;
        TxData  = RdData;
    end

endmodule
